// File: rtl/bpf_alu_mc_if.sv
// Bus between the bpfcpu controller and the multi-cycle ALU.
// Master (controller) drives operands, select, issue strobe and acknowledge;
// slave (ALU) returns the registered result, flags, error, busy and valid.
//   A, B      : operands (WIDTH bits)
//   ALU_sel   : operation select (4 bits)
//   ALU_en    : issue strobe
//   ALU_ack   : consumer accepts the current result
//   ALU_out   : registered result
//   set/eq/gt/ge : registered compare flags captured at issue
//   ALU_err   : result invalid (divide by zero or op not built)
//   ALU_busy  : iterative operation in progress
//   ALU_vld   : result valid, held until acknowledged
interface bpf_alu_mc_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_sel;
  logic             ALU_en;
  logic             ALU_ack;
  logic [WIDTH-1:0] ALU_out;
  logic             set;
  logic             eq;
  logic             gt;
  logic             ge;
  logic             ALU_err;
  logic             ALU_busy;
  logic             ALU_vld;

  modport master (
    output A, B, ALU_sel, ALU_en, ALU_ack,
    input  ALU_out, set, eq, gt, ge, ALU_err, ALU_busy, ALU_vld
  );

  modport slave (
    input  A, B, ALU_sel, ALU_en, ALU_ack,
    output ALU_out, set, eq, gt, ge, ALU_err, ALU_busy, ALU_vld
  );
endinterface

// File: rtl/bpf_alu_mc.sv
// Multi-cycle BPF VM ALU. Single-cycle ops complete one clock after issue;
// multiply (shift-add) and divide/modulus (restoring) retire one bit per
// cycle and complete WIDTH+1 clocks after issue.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts any operation in flight)
//   bus : bpf_alu_mc_if slave modport (operands in, result/flags/status out)
module bpf_alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  bpf_alu_mc_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_OR  = 4'd4, OP_AND = 4'd5, OP_LSH = 4'd6, OP_RSH = 4'd7,
                         OP_NEG = 4'd8, OP_MOD = 4'd9, OP_XOR = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  // Shift amounts of WIDTH or more clear the result instead of wrapping.
  function automatic logic shift_oob(input logic [WIDTH-1:0] b);
    return b >= WIDTH'(WIDTH);
  endfunction

  function automatic logic [WIDTH-1:0] alu_single(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       sel);
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_OR:  r = a | b;
      OP_AND: r = a & b;
      OP_LSH: r = shift_oob(b) ? '0 : (a << b);
      OP_RSH: r = shift_oob(b) ? '0 : (a >> b);
      OP_NEG: r = '0 - a;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d, vld_q, vld_d;
  logic             set_q, set_d, eq_q, eq_d, gt_q, gt_d, ge_q, ge_d;

  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic             is_mod_q, is_mod_d;

  logic             accept;
  logic             is_div_sel;
  logic [WIDTH-1:0] prod_nx;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign accept     = (state_q == S_IDLE) && (!vld_q || bus.ALU_ack);
  assign is_div_sel = (bus.ALU_sel == OP_DIV) || (bus.ALU_sel == OP_MOD);

  // One shift-add multiplier step.
  assign prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // One restoring-division step. The partial remainder stays below the
  // divisor, so after a successful subtract the low WIDTH bits are exact.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge = rem_sh >= {1'b0, dvsr_q};
  assign rem_nx = rem_ge ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], rem_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    err_d    = err_q;
    vld_d    = vld_q;
    set_d    = set_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    ge_d     = ge_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    is_mod_d = is_mod_q;

    if (vld_q && bus.ALU_ack) vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.ALU_en) begin
          set_d = (bus.A & bus.B) != '0;
          eq_d  = bus.A == bus.B;
          gt_d  = bus.A > bus.B;
          ge_d  = bus.A >= bus.B;
          err_d = 1'b0;
          if (MUL_EN && (bus.ALU_sel == OP_MUL)) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            prod_d   = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = S_MUL;
          end else if (DIV_EN && is_div_sel && (bus.B != '0)) begin
            quo_d    = bus.A;
            dvsr_d   = bus.B;
            rem_d    = '0;
            is_mod_d = bus.ALU_sel == OP_MOD;
            cnt_d    = CW'(WIDTH);
            state_d  = S_DIV;
          end else begin
            // Unbuilt multiply and any divide/mod not taking the iterative
            // path (zero divisor or divider not built) complete as errors.
            if ((bus.ALU_sel == OP_MUL) || is_div_sel) begin
              out_d = '0;
              err_d = 1'b1;
            end else begin
              out_d = alu_single(bus.A, bus.B, bus.ALU_sel);
            end
            vld_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = prod_nx;
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = is_mod_q ? rem_nx : quo_nx;
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible outputs: reset to zero / IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      set_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      ge_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      set_q   <= set_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      ge_q    <= ge_d;
    end
  end

  // Iteration datapath: only meaningful while in MUL/DIV, so no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvsr_q   <= dvsr_d;
    is_mod_q <= is_mod_d;
  end

  assign bus.ALU_out  = out_q;
  assign bus.ALU_err  = err_q;
  assign bus.ALU_vld  = vld_q;
  assign bus.ALU_busy = state_q != S_IDLE;
  assign bus.set      = set_q;
  assign bus.eq       = eq_q;
  assign bus.gt       = gt_q;
  assign bus.ge       = ge_q;
endmodule

// File: tb/tb_bpf_alu_mc.sv
module tb_bpf_alu_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpf_alu_mc_if #(.WIDTH(W)) bus ();
  bpf_alu_mc_if #(.WIDTH(W)) bus2 ();

  bpf_alu_mc #(.WIDTH(W), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  bpf_alu_mc #(.WIDTH(W), .MUL_EN(1'b0), .DIV_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_of(input logic [W-1:0] a, input logic [W-1:0] b);
    return {(a & b) != '0, a == b, a > b, a >= b};
  endfunction

  // Iterative op: issue, try a second issue while busy, time the result.
  task automatic run_iter(input string name, input logic [3:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_out,
                          input logic [W-1:0] hold_out);
    int lat;
    int busy_cnt;
    bus.A = a; bus.B = b; bus.ALU_sel = sel; bus.ALU_en = 1'b1; bus.ALU_ack = 1'b0;
    tick();
    lat = 1;
    busy_cnt = 0;
    check({name, " hold_out"}, bus.ALU_out, hold_out);
    bus.A = 32'h9; bus.B = 32'h7; bus.ALU_sel = 4'd0;
    while (bus.ALU_vld !== 1'b1 && lat < 100) begin
      if (bus.ALU_busy === 1'b1) busy_cnt++;
      if (lat == 5) bus.ALU_en = 1'b0;
      tick();
      lat++;
    end
    bus.ALU_en = 1'b0;
    check({name, " latency"}, lat, W + 1);
    check({name, " busy_cycles"}, busy_cnt, W);
    check({name, " out"}, bus.ALU_out, exp_out);
    check({name, " err"}, bus.ALU_err, 1'b0);
    check({name, " flags"}, {bus.set, bus.eq, bus.gt, bus.ge}, flags_of(a, b));
    bus.ALU_ack = 1'b1;
    tick();
    check({name, " vld_after_ack"}, bus.ALU_vld, 1'b0);
    bus.ALU_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h2,    32'h00000001, 1'b0};
    vecs[1]  = '{4'd1,  32'h5,        32'h7,    32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{4'd4,  32'hF0,       32'h0F,   32'hFF,       1'b0};
    vecs[3]  = '{4'd5,  32'hF0,       32'h3C,   32'h30,       1'b0};
    vecs[4]  = '{4'd6,  32'h1,        32'd32,   32'h0,        1'b0};
    vecs[5]  = '{4'd6,  32'h1,        32'd31,   32'h80000000, 1'b0};
    vecs[6]  = '{4'd7,  32'h80000000, 32'd31,   32'h1,        1'b0};
    vecs[7]  = '{4'd7,  32'h80000000, 32'd40,   32'h0,        1'b0};
    vecs[8]  = '{4'd8,  32'h1,        32'h0,    32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{4'd3,  32'h5,        32'h0,    32'h0,        1'b1};
    vecs[10] = '{4'd9,  32'h5,        32'h0,    32'h0,        1'b1};
    vecs[11] = '{4'd11, 32'h3,        32'h3,    32'h0,        1'b0};
    vecs[12] = '{4'd15, 32'hFF,       32'h1,    32'h0,        1'b0};
    vecs[13] = '{4'd10, 32'hFF00,     32'h0FF0, 32'hF0F0,     1'b0};

    rst = 1'b1;
    bus.A = '0; bus.B = '0; bus.ALU_sel = '0; bus.ALU_en = 1'b0; bus.ALU_ack = 1'b0;
    bus2.A = '0; bus2.B = '0; bus2.ALU_sel = '0; bus2.ALU_en = 1'b0; bus2.ALU_ack = 1'b0;
    repeat (3) tick();
    check("reset out", bus.ALU_out, 0);
    check("reset status", {bus.ALU_vld, bus.ALU_busy, bus.ALU_err}, 3'b000);
    check("reset flags", {bus.set, bus.eq, bus.gt, bus.ge}, 4'b0000);
    rst = 1'b0;
    tick();

    // Back-to-back single-cycle ops with ack held high.
    bus.ALU_ack = 1'b1;
    bus.ALU_en  = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.A = vecs[i].a; bus.B = vecs[i].b; bus.ALU_sel = vecs[i].sel;
      tick();
      check($sformatf("vec%0d out", i), bus.ALU_out, vecs[i].out);
      check($sformatf("vec%0d err", i), bus.ALU_err, vecs[i].err);
      check($sformatf("vec%0d vld", i), bus.ALU_vld, 1'b1);
      check($sformatf("vec%0d busy", i), bus.ALU_busy, 1'b0);
      check($sformatf("vec%0d flags", i), {bus.set, bus.eq, bus.gt, bus.ge},
            flags_of(vecs[i].a, vecs[i].b));
    end
    bus.ALU_en = 1'b0;
    tick();
    check("vld clears after ack", bus.ALU_vld, 1'b0);
    check("out held after ack", bus.ALU_out, 32'hF0F0);
    bus.ALU_ack = 1'b0;

    // Ack while nothing is valid is a no-op.
    bus.ALU_ack = 1'b1;
    tick();
    check("idle ack vld", bus.ALU_vld, 1'b0);
    bus.ALU_ack = 1'b0;

    run_iter("mul", 4'd2, 32'h00010000, 32'h00010001, 32'h00010000, 32'hF0F0);
    run_iter("div", 4'd3, 32'd100, 32'd7, 32'd14, 32'h00010000);
    run_iter("mod", 4'd9, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset in the middle of a divide.
    bus.A = 32'd100; bus.B = 32'd7; bus.ALU_sel = 4'd3; bus.ALU_en = 1'b1;
    tick();
    bus.ALU_en = 1'b0;
    repeat (9) tick();
    check("pre-reset busy", bus.ALU_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("midop reset out", bus.ALU_out, 0);
    check("midop reset status", {bus.ALU_vld, bus.ALU_busy, bus.ALU_err}, 3'b000);
    check("midop reset flags", {bus.set, bus.eq, bus.gt, bus.ge}, 4'b0000);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ALU_vld === 1'b1 || bus.ALU_busy === 1'b1) seen++;
    end
    check("aborted op stays silent", seen, 0);

    // Instance built without multiplier/divider.
    bus2.ALU_ack = 1'b1;
    bus2.ALU_en  = 1'b1;
    bus2.A = 32'd3; bus2.B = 32'd4; bus2.ALU_sel = 4'd0;
    tick();
    check("nomul add out", bus2.ALU_out, 32'd7);
    check("nomul add err", bus2.ALU_err, 1'b0);
    bus2.ALU_sel = 4'd2;
    tick();
    check("nomul mul out", bus2.ALU_out, 0);
    check("nomul mul status", {bus2.ALU_vld, bus2.ALU_busy, bus2.ALU_err}, 3'b101);
    bus2.B = 32'd7; bus2.ALU_sel = 4'd3;
    tick();
    check("nodiv div status", {bus2.ALU_vld, bus2.ALU_busy, bus2.ALU_err}, 3'b101);
    check("nodiv div out", bus2.ALU_out, 0);
    bus2.ALU_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
